// File: rtl/bus_slave_pkg.sv
// rtl/bus_slave_pkg.sv - shared encodings and constants for the 8085 bus responder
package bus_slave_pkg;

    localparam int CNT_W = 4;
    localparam logic [7:0] RST7_OPC = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_WAIT = 4'b0010,
        S_LAST = 4'b0100,
        S_STRB = 4'b1000
    } state_t;

endpackage

// File: rtl/bus_slave_addr_match.sv
// rtl/bus_slave_addr_match.sv - window comparator for the latched bus address
module addr_match #(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter int          ADDR_BITS = 8,
    parameter bit          IS_IO     = 1'b0
) (
    input  logic [15:0] addr,
    input  logic        iom,
    output logic        hit
);

    // I/O space is only 8 bits wide, so the high byte never takes part
    logic [15:0] cmp_addr;
    logic [15:0] cmp_base;

    assign cmp_addr = IS_IO ? {8'h00, addr[7:0]} : addr;
    assign cmp_base = IS_IO ? {8'h00, BASE_ADDR[7:0]} : BASE_ADDR;
    assign hit      = (iom == IS_IO) && ((cmp_addr >> ADDR_BITS) == (cmp_base >> ADDR_BITS));

endmodule

// File: rtl/bus_slave.sv
// rtl/bus_slave.sv - 8085 multiplexed-bus responder with wait states, local port and INTA opcode
module bus_slave
    import bus_slave_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter int          ADDR_BITS = 8,
    parameter bit          IS_IO     = 1'b0,
    parameter int          WAIT_CNT  = 0,
    parameter bit          INTA_EN   = 1'b0,
    parameter logic [7:0]  INTA_OPC  = RST7_OPC
) (
    input  logic                 clk_,
    input  logic                 rst_,
    inout  wire  [7:0]           bus_ad,
    input  logic [7:0]           bus_ah,
    input  logic                 ale,
    input  logic                 rd_,
    input  logic                 wr_,
    input  logic                 iom_,
    input  logic                 inta_,
    output logic                 ready,
    output logic [ADDR_BITS-1:0] loc_addr,
    output logic                 loc_re,
    input  logic [7:0]           loc_rdata,
    output logic                 loc_we,
    output logic [7:0]           loc_wdata
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      addr_full;
    logic             hit;
    logic             drive;
    logic [7:0]       drive_data;

    assign addr_full = {bus_ah, bus_ad};

    addr_match #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_BITS (ADDR_BITS),
        .IS_IO     (IS_IO)
    ) u_match (
        .addr (addr_full),
        .iom  (iom_),
        .hit  (hit)
    );

    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (ale) begin
            state_nx = !hit ? S_IDLE : ((WAIT_CNT > 0) ? S_WAIT : S_LAST);
        end else begin
            case (state)
                S_WAIT:  if (cnt == CNT_W'(1)) state_nx = S_LAST;
                S_LAST:  state_nx = S_STRB;
                S_STRB:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // The commit fires off STRB, so loc_addr still holds the old offset while loc_we is high
    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) begin
            ready     <= 1'b1;
            cnt       <= '0;
            loc_we    <= 1'b0;
            loc_wdata <= 8'h00;
            loc_addr  <= '0;
        end else begin
            loc_we <= (state == S_STRB) && !wr_;
            if ((state == S_STRB) && !wr_) begin
                loc_wdata <= bus_ad;
            end
            if (ale) begin
                loc_addr <= addr_full[ADDR_BITS-1:0];
                cnt      <= CNT_W'(WAIT_CNT);
                ready    <= !(hit && (WAIT_CNT > 0));
            end else if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    ready <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        loc_re     = (state != S_IDLE) && !rd_;
        drive      = rst_ && (((state != S_IDLE) && !rd_) || (INTA_EN && !inta_));
        drive_data = !inta_ ? INTA_OPC : loc_rdata;
    end

    assign bus_ad = drive ? drive_data : 8'hzz;

endmodule

// File: tb/tb_bus_slave.sv
// tb/tb_bus_slave.sv - bench for bus_slave across memory, wait-state, I/O and INTA configurations
module tb_bus_slave;

    logic clk_ = 1'b0;
    always #5 clk_ = ~clk_;

    logic       rst_, ale, rd_, wr_, iom_, inta_, tb_oe, started;
    logic [7:0] bus_ah, tb_ad, loc_rdata;
    wire  [7:0] ad0, ad1, ad2, ad3;
    wire  [7:0] adv [4];
    wire        rdy [4];
    wire        we [4];
    wire        re [4];
    wire  [7:0] wd [4];
    wire  [7:0] la [4];
    wire  [3:0] la_io;

    assign ad0 = tb_oe ? tb_ad : 8'hzz;
    assign ad1 = tb_oe ? tb_ad : 8'hzz;
    assign ad2 = tb_oe ? tb_ad : 8'hzz;
    assign ad3 = tb_oe ? tb_ad : 8'hzz;
    assign adv[0] = ad0;
    assign adv[1] = ad1;
    assign adv[2] = ad2;
    assign adv[3] = ad3;
    assign la[2]  = {4'h0, la_io};

    // 0: mem no wait, 1: mem 2 waits, 2: I/O window 40..4F 1 wait, 3: mem 3 waits + INTA
    localparam int          NW    [4] = '{0, 2, 1, 3};
    localparam logic [15:0] BASE  [4] = '{16'h8000, 16'h8000, 16'h0040, 16'h8000};
    localparam int          AB    [4] = '{8, 8, 4, 8};
    localparam bit          ISIO  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam bit          INTAE [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    bus_slave #(.BASE_ADDR(16'h8000), .ADDR_BITS(8), .IS_IO(1'b0), .WAIT_CNT(0), .INTA_EN(1'b0), .INTA_OPC(8'hFF)) u_m0 (
        .clk_(clk_), .rst_(rst_), .bus_ad(ad0), .bus_ah(bus_ah), .ale(ale), .rd_(rd_), .wr_(wr_),
        .iom_(iom_), .inta_(inta_), .ready(rdy[0]), .loc_addr(la[0]), .loc_re(re[0]),
        .loc_rdata(loc_rdata), .loc_we(we[0]), .loc_wdata(wd[0]));
    bus_slave #(.BASE_ADDR(16'h8000), .ADDR_BITS(8), .IS_IO(1'b0), .WAIT_CNT(2), .INTA_EN(1'b0), .INTA_OPC(8'hFF)) u_m2 (
        .clk_(clk_), .rst_(rst_), .bus_ad(ad1), .bus_ah(bus_ah), .ale(ale), .rd_(rd_), .wr_(wr_),
        .iom_(iom_), .inta_(inta_), .ready(rdy[1]), .loc_addr(la[1]), .loc_re(re[1]),
        .loc_rdata(loc_rdata), .loc_we(we[1]), .loc_wdata(wd[1]));
    bus_slave #(.BASE_ADDR(16'h0040), .ADDR_BITS(4), .IS_IO(1'b1), .WAIT_CNT(1), .INTA_EN(1'b0), .INTA_OPC(8'hFF)) u_io (
        .clk_(clk_), .rst_(rst_), .bus_ad(ad2), .bus_ah(bus_ah), .ale(ale), .rd_(rd_), .wr_(wr_),
        .iom_(iom_), .inta_(inta_), .ready(rdy[2]), .loc_addr(la_io), .loc_re(re[2]),
        .loc_rdata(loc_rdata), .loc_we(we[2]), .loc_wdata(wd[2]));
    bus_slave #(.BASE_ADDR(16'h8000), .ADDR_BITS(8), .IS_IO(1'b0), .WAIT_CNT(3), .INTA_EN(1'b1), .INTA_OPC(8'hFF)) u_int (
        .clk_(clk_), .rst_(rst_), .bus_ad(ad3), .bus_ah(bus_ah), .ale(ale), .rd_(rd_), .wr_(wr_),
        .iom_(iom_), .inta_(inta_), .ready(rdy[3]), .loc_addr(la[3]), .loc_re(re[3]),
        .loc_rdata(loc_rdata), .loc_we(we[3]), .loc_wdata(wd[3]));

    int nchk = 0;
    int nerr = 0;
    int low_cnt [4] = '{default: 0};
    int we_cnt  [4] = '{default: 0};
    logic [7:0] t3_ad [4];

    task automatic check(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s u%0d: got %h want %h", nm, i, act, exp);
        end
    endtask

    // Undriven bus reads as z (4-state) or 0 (2-state); DUT data is never 0 here
    task automatic check_z(input string nm, input int i, input logic [7:0] v);
        nchk++;
        if (!(v === 8'hzz || v === 8'h00)) begin
            nerr++;
            $display("FAIL %s u%0d: got %h want released", nm, i, v);
        end
    endtask

    function automatic bit in_window(input int i, input logic [15:0] a, input logic io);
        if (ISIO[i]) return io && ((a[7:0] >> AB[i]) == (BASE[i][7:0] >> AB[i]));
        return !io && ((a >> AB[i]) == (BASE[i] >> AB[i]));
    endfunction

    // Model: k counts clocks since the ALE edge; a hit cycle is busy for k=1..N+2, stalls k=1..N
    bit          m_hit  [4];
    int          m_k    [4];
    bit          m_we   [4];
    logic [7:0]  m_wd   [4];
    logic [15:0] m_addr [4];

    always @(posedge clk_ or negedge rst_) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_) begin
                m_hit[i] <= 1'b0; m_k[i] <= 0; m_we[i] <= 1'b0; m_wd[i] <= 8'h00; m_addr[i] <= 16'h0;
            end else begin
                m_we[i] <= m_hit[i] && (m_k[i] == NW[i] + 2) && !wr_;
                if (m_hit[i] && (m_k[i] == NW[i] + 2) && !wr_) m_wd[i] <= adv[i];
                if (ale) begin
                    m_addr[i] <= {bus_ah, adv[i]};
                    m_hit[i]  <= in_window(i, {bus_ah, adv[i]}, iom_);
                    m_k[i]    <= 1;
                end else if (m_k[i] < 100) begin
                    m_k[i] <= m_k[i] + 1;
                end
            end
        end
    end

    bit e_act, e_drv;
    always @(negedge clk_) begin
        if (started) begin
            for (int i = 0; i < 4; i++) begin
                e_act = m_hit[i] && (m_k[i] >= 1) && (m_k[i] <= NW[i] + 2);
                e_drv = rst_ && ((e_act && !rd_) || (INTAE[i] && !inta_));
                check("ready", i, 16'(rdy[i]), 16'(!(m_hit[i] && m_k[i] >= 1 && m_k[i] <= NW[i])));
                check("loc_re", i, 16'(re[i]), 16'(e_act && !rd_));
                check("loc_we", i, 16'(we[i]), 16'(m_we[i]));
                check("loc_wdata", i, 16'(wd[i]), 16'(m_wd[i]));
                check("loc_addr", i, 16'(la[i]), m_addr[i] & ((16'h1 << AB[i]) - 16'h1));
                if (!tb_oe) begin
                    if (e_drv) check("bus_ad", i, 16'(adv[i]), 16'(!inta_ ? 8'hFF : loc_rdata));
                    else check_z("bus_z", i, adv[i]);
                end
                if (!rdy[i]) low_cnt[i]++;
                if (we[i]) we_cnt[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_);
        #1;
    endtask

    // kind: 0 read, 1 write, 2 interrupt acknowledge; tw = TW states the CPU inserts
    task automatic bus_cycle(input logic [15:0] a, input logic io, input int kind, input logic [7:0] d, input int tw);
        ale = 1'b1; bus_ah = a[15:8]; tb_ad = a[7:0]; tb_oe = 1'b1; iom_ = io;
        rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
        tick();
        ale = 1'b0;
        if (kind == 1) begin
            tb_ad = d; wr_ = 1'b0;
        end else begin
            tb_oe = 1'b0;
            if (kind == 0) rd_ = 1'b0; else inta_ = 1'b0;
        end
        repeat (tw + 1) tick();
        #3;
        for (int i = 0; i < 4; i++) t3_ad[i] = adv[i];
        tick();
        rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic aborted_cycle(input logic is_wr);
        int wc;
        wc = we_cnt[3];
        ale = 1'b1; bus_ah = 8'h80; tb_ad = 8'h56; tb_oe = 1'b1; iom_ = 1'b0;
        tick();
        ale = 1'b0;
        if (is_wr) begin tb_ad = 8'h99; wr_ = 1'b0; end
        else begin tb_oe = 1'b0; rd_ = 1'b0; end
        tick();
        check("abort_ready_pre", 3, 16'(rdy[3]), 16'h0);
        rst_ = 1'b0;
        #1;
        check("abort_ready", 3, 16'(rdy[3]), 16'h1);
        if (!is_wr) check_z("abort_bus_z", 3, adv[3]);
        @(posedge clk_);
        #1;
        rst_ = 1'b1;
        repeat (3) tick();
        rd_ = 1'b1; wr_ = 1'b1; tb_oe = 1'b0;
        repeat (2) tick();
        check("abort_no_we", 3, 16'(we_cnt[3]), 16'(wc));
        check("abort_wdata", 3, 16'(wd[3]), 16'h00);
    endtask

    initial begin
        int lc;
        started = 1'b0;
        rst_ = 1'b0; ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1; iom_ = 1'b1; inta_ = 1'b1;
        tb_oe = 1'b0; tb_ad = 8'h00; bus_ah = 8'h00; loc_rdata = 8'hA5;
        repeat (2) @(posedge clk_);
        #1;
        started = 1'b1;
        check("rst_ready", 3, 16'(rdy[3]), 16'h1);
        check("rst_addr", 0, 16'(la[0]), 16'h0);
        tick();
        rst_ = 1'b1;
        tick();

        bus_cycle(16'h8012, 1'b0, 0, 8'h00, 0);
        check("rd0_t3", 0, 16'(t3_ad[0]), 16'h00A5);
        check("rd0_addr", 0, 16'(la[0]), 16'h0012);
        check("rd0_nowait", 0, 16'(low_cnt[0]), 16'h0);
        check("rd0_wait2", 1, 16'(low_cnt[1]), 16'h2);

        bus_cycle(16'h8012, 1'b0, 0, 8'h00, 2);
        check("rd2_t3", 1, 16'(t3_ad[1]), 16'h00A5);
        check("rd2_wait2", 1, 16'(low_cnt[1]), 16'h4);

        bus_cycle(16'h8034, 1'b0, 1, 8'h5A, 0);
        check("wr_we", 0, 16'(we[0]), 16'h1);
        check("wr_wdata", 0, 16'(wd[0]), 16'h005A);
        check("wr_addr_old", 0, 16'(la[0]), 16'h0034);
        bus_cycle(16'h8035, 1'b0, 0, 8'h00, 0);
        check("b2b_addr", 0, 16'(la[0]), 16'h0035);
        check("wr_one_pulse", 0, 16'(we_cnt[0]), 16'h1);

        bus_cycle(16'h9000, 1'b0, 0, 8'h00, 0);
        check_z("miss_z", 0, t3_ad[0]);
        bus_cycle(16'h8000, 1'b1, 0, 8'h00, 0);
        check_z("iom_z", 1, t3_ad[1]);
        check("miss_no_we", 0, 16'(we_cnt[0]), 16'h1);

        bus_cycle(16'h4343, 1'b1, 1, 8'h77, 1);
        check("out_we", 2, 16'(we[2]), 16'h1);
        check("out_addr", 2, 16'(la[2]), 16'h0003);
        check("out_wdata", 2, 16'(wd[2]), 16'h0077);
        bus_cycle(16'h0043, 1'b0, 1, 8'h11, 1);
        check("memwr_ignored", 2, 16'(we_cnt[2]), 16'h1);
        check("memwr_wdata", 2, 16'(wd[2]), 16'h0077);

        lc = low_cnt[3];
        bus_cycle(16'h0100, 1'b1, 2, 8'h00, 0);
        check("inta_opc", 3, 16'(t3_ad[3]), 16'h00FF);
        check_z("inta_off_z", 0, t3_ad[0]);
        check("inta_no_stall", 3, 16'(low_cnt[3]), 16'(lc));

        aborted_cycle(1'b0);
        aborted_cycle(1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
